mips_wait_mem: RTL and testbench

Parametrised word-addressed data/instruction memory for the multicycle MIPS core. It replaces the fixed one-cycle negedge RAM with a posedge, request/ready memory. Access latency is configurable, byte-lane writes are supported, and out-of-range accesses are flagged. The CPU holds its memory state until RDY, so any latency from 0 to 15 wait cycles is usable.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/byte_ram.sv | 44 ++++
 rtl/mips_wait_mem.sv | 143 ++++++++++++++
 tb/tb_mips_wait_mem.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the wait-state memory
// Purpose: FSM state encoding, wait counter width and byte-lane helpers
// shared by mips_wait_mem and byte_ram.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wait counter covers LATENCY 0..15.
  localparam int CNT_W = 4;

  // Byte-lane count for the default 32-bit word.
  localparam int BE_W = 32 / 8;

  // Byte-lane count for an arbitrary word width (must be a multiple of 8).
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - DEPTH x DATA_W array with per-byte writes and registered read
// Purpose: storage array for mips_wait_mem.
// Ports:
//   clk_i    clock, all updates on posedge
//   we_i     write strobe; bytes with be_i[i]=1 are written
//   re_i     read strobe; rdata_o captures the addressed word
//   be_i     byte enables
//   addr_i   word address (caller guarantees addr_i < DEPTH when strobing)
//   wdata_i  write data
//   rdata_o  registered read data, holds between reads
module byte_ram
  import mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 128,
  parameter int    RAM_AW    = 7,
  parameter string INIT_FILE = ""
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic                        re_i,
  input  logic [be_width(DATA_W)-1:0] be_i,
  input  logic [RAM_AW-1:0]           addr_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int BEW = be_width(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BEW; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_wait_mem.sv
// rtl/mips_wait_mem.sv - request/ready word memory with configurable wait states
// Purpose: multicycle MIPS data/instruction memory; accepts a request in IDLE,
// waits LATENCY cycles, pulses RDY for one cycle with ERR on out-of-range.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   CS, WE, BE, ADDR, WDATA   request, sampled only in IDLE
//   RDATA             read data, holds until next completed read or reset
//   RDY, ERR          one-cycle completion pulse and out-of-range flag
//   BUSY              high in WAIT and DONE
module mips_wait_mem
  import mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 7,
  parameter int    DEPTH     = 128,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CS,
  input  logic                        WE,
  input  logic [be_width(DATA_W)-1:0] BE,
  input  logic [ADDR_W-1:0]           ADDR,
  input  logic [DATA_W-1:0]           WDATA,
  output logic [DATA_W-1:0]           RDATA,
  output logic                        RDY,
  output logic                        ERR,
  output logic                        BUSY
);

  localparam int                BEW     = be_width(DATA_W);
  localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(LATENCY);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [BEW-1:0]     be_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               rdy_q, err_q, busy_q, rd_valid_q;

  // Access seen by the array on the posedge entering DONE. With LATENCY=0
  // that posedge is the accepting one, so the live request is used.
  logic               go_done_d;
  logic               acc_we_d;
  logic [BEW-1:0]     acc_be_d;
  logic [ADDR_W-1:0]  acc_addr_d;
  logic [DATA_W-1:0]  acc_wdata_d;
  logic               acc_ok_d;
  logic [DATA_W-1:0]  ram_rdata;

  always_comb begin
    go_done_d   = 1'b0;
    acc_we_d    = we_q;
    acc_be_d    = be_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        acc_we_d    = WE;
        acc_be_d    = BE;
        acc_addr_d  = ADDR;
        acc_wdata_d = WDATA;
        go_done_d   = CS && (LATENCY == 0);
      end
      WAIT:    go_done_d = (cnt_q == CNT_W'(1));
      default: go_done_d = 1'b0;
    endcase
    // Reset wins over a completing access: nothing is committed.
    if (RST) go_done_d = 1'b0;
    acc_ok_d = ({1'b0, acc_addr_d} < DEPTH_C);
  end

  byte_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RAM_AW    (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (go_done_d && acc_we_d && acc_ok_d),
    .re_i    (go_done_d && !acc_we_d && acc_ok_d),
    .be_i    (acc_be_d),
    .addr_i  (acc_addr_d[RAM_AW-1:0]),
    .wdata_i (acc_wdata_d),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CS) begin
            we_q    <= WE;
            be_q    <= BE;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            cnt_q   <= LAT_C;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (go_done_d) begin
        rdy_q <= 1'b1;
        err_q <= !acc_ok_d;
        // An out-of-range read forces RDATA to zero; writes leave it alone.
        if (!acc_we_d) rd_valid_q <= acc_ok_d;
      end
    end
  end

  assign RDATA = rd_valid_q ? ram_rdata : '0;
  assign RDY   = rdy_q;
  assign ERR   = err_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_mips_wait_mem.sv
// tb/tb_mips_wait_mem.sv - self-checking bench for mips_wait_mem
module tb_mips_wait_mem;

  localparam int LAT [2] = '{2, 0};
  localparam int DEP [2] = '{100, 128};

  logic        clk = 1'b0;
  logic        rst;
  logic        cs [2];
  logic        we;
  logic [3:0]  be;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata [2];
  logic        rdy [2];
  logic        err [2];
  logic        busy [2];

  logic [31:0] model [2][128];
  logic [31:0] last_rd [2];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mips_wait_mem #(.DATA_W(32), .ADDR_W(7), .DEPTH(100), .LATENCY(2), .INIT_FILE("")) u_dut_a (
    .CLK(clk), .RST(rst), .CS(cs[0]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata[0]), .RDY(rdy[0]), .ERR(err[0]), .BUSY(busy[0])
  );

  mips_wait_mem #(.DATA_W(32), .ADDR_W(7), .DEPTH(128), .LATENCY(0), .INIT_FILE("")) u_dut_b (
    .CLK(clk), .RST(rst), .CS(cs[1]), .WE(we), .BE(be), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata[1]), .RDY(rdy[1]), .ERR(err[1]), .BUSY(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on instance s; model decides latency, ERR and RDATA.
  task automatic do_req(input int s, input logic w, input logic [6:0] a,
                        input logic [3:0] b, input logic [31:0] wd, input bit scramble);
    logic [31:0] exp_rd;
    bit          oor;
    int          k;
    oor = (int'(a) >= DEP[s]);
    if (w) begin
      if (!oor)
        for (int i = 0; i < 4; i++)
          if (b[i]) model[s][a][8*i +: 8] = wd[8*i +: 8];
      exp_rd = last_rd[s];
    end else begin
      exp_rd = oor ? 32'h0 : model[s][a];
      last_rd[s] = exp_rd;
    end
    we = w; be = b; addr = a; wdata = wd; cs[s] = 1'b1;
    @(posedge clk); #1;
    cs[s] = 1'b0;
    k = 0;
    while (!rdy[s] && k < 20) begin
      chk("busy_wait", 32'(busy[s]), 32'd1);
      if (scramble) begin
        addr = 7'($urandom); wdata = $urandom; be = 4'($urandom);
        we = 1'($urandom); cs[s] = 1'($urandom);
      end
      @(posedge clk); #1;
      k++;
    end
    cs[s] = 1'b0;
    chk("latency", 32'(k), 32'(LAT[s]));
    chk("busy_rdy", 32'(busy[s]), 32'd1);
    chk("err", 32'(err[s]), 32'(oor));
    chk("rdata", rdata[s], exp_rd);
    @(posedge clk); #1;
    chk("rdy_pulse", 32'(rdy[s]), 32'd0);
    chk("err_idle", 32'(err[s]), 32'd0);
    chk("busy_idle", 32'(busy[s]), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; cs[0] = 1'b0; cs[1] = 1'b0;
    we = 1'b0; be = 4'h0; addr = 7'd0; wdata = 32'h0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_rdy", 32'(rdy[s]), 32'd0);
      chk("rst_err", 32'(err[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
      chk("rst_rdata", rdata[s], 32'h0);
    end
    rst = 1'b0;

    // Give every word a defined value (out-of-range writes must not land).
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 128; a++)
        do_req(s, 1'b1, 7'(a), 4'hF, $urandom, 1'b0);

    // Full-word write/read, then byte lanes and an empty write.
    do_req(0, 1'b1, 7'd5, 4'hF, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b0, 7'd5, 4'h0, 32'h0, 1'b0);
    chk("t1_const", rdata[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 7'd5, 4'b0101, 32'h11223344, 1'b0);
    do_req(0, 1'b0, 7'd5, 4'hF, 32'h0, 1'b0);
    chk("t2_const", rdata[0], 32'hDE22BE44);
    do_req(0, 1'b1, 7'd5, 4'h0, 32'h55555555, 1'b0);
    do_req(0, 1'b0, 7'd5, 4'h0, 32'h0, 1'b0);
    chk("t2_be0", rdata[0], 32'hDE22BE44);

    // Out-of-range read/write on the 100-word instance, then RAM[0] intact.
    do_req(0, 1'b0, 7'd120, 4'hF, 32'h0, 1'b0);
    chk("oor_rdata0", rdata[0], 32'h0);
    do_req(0, 1'b1, 7'd100, 4'hF, 32'hA5A5A5A5, 1'b0);
    do_req(0, 1'b0, 7'd0, 4'hF, 32'h0, 1'b0);

    // LATENCY=0, CS held: one RDY every second cycle.
    we = 1'b0; addr = 7'd3; be = 4'hF; cs[1] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("l0_pattern", 32'(rdy[1]), 32'((i % 2) == 0));
      if (rdy[1]) pulses++;
    end
    cs[1] = 1'b0;
    chk("l0_pulses", 32'(pulses), 32'd2);
    last_rd[1] = model[1][3];
    chk("l0_rdata", rdata[1], last_rd[1]);
    @(posedge clk); #1;

    // Reset one cycle after accepting a write: write is discarded.
    we = 1'b1; be = 4'hF; addr = 7'd9; wdata = 32'hCAFEF00D; cs[0] = 1'b1;
    @(posedge clk); #1;
    cs[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_rdy", 32'(rdy[0]), 32'd0);
    chk("rstmid_err", 32'(err[0]), 32'd0);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_rdata", rdata[0], 32'h0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    // Reset and CS together: request is dropped.
    cs[1] = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; cs[1] = 1'b0;
    @(posedge clk); #1;
    chk("rstcs_busy", 32'(busy[1]), 32'd0);
    chk("rstcs_rdy", 32'(rdy[1]), 32'd0);
    do_req(0, 1'b0, 7'd9, 4'hF, 32'h0, 1'b0);

    // Randomized traffic with inputs scrambled while busy.
    for (int n = 0; n < 400; n++)
      do_req(int'($urandom_range(1, 0)), 1'($urandom), 7'($urandom),
             4'($urandom), $urandom, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
